// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO port responder: register offsets, CTRL bits, default window.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

  // Byte offsets within the 32-byte window
  localparam logic [4:0] OFS_PORT_OUT  = 5'h00;
  localparam logic [4:0] OFS_PORT_IN   = 5'h04;
  localparam logic [4:0] OFS_EDGE_STAT = 5'h08;
  localparam logic [4:0] OFS_EDGE_MASK = 5'h0C;
  localparam logic [4:0] OFS_TMR_COUNT = 5'h10;
  localparam logic [4:0] OFS_TMR_CMP   = 5'h14;
  localparam logic [4:0] OFS_CTRL      = 5'h18;

  // CTRL register bit positions
  localparam int unsigned CTRL_TMR_EN     = 0;
  localparam int unsigned CTRL_TMR_FLAG   = 1;
  localparam int unsigned CTRL_TMR_IRQ_EN = 2;

  // Word index (Address[4:2]) to byte offset; byte lanes are ignored
  function automatic logic [4:0] word_to_offset(input logic [2:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/input_sync_edge.sv
// Two-flop synchronizer for asynchronous inputs with a rising-edge detector behind it.
module input_sync_edge #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;

  // Synchronizer chain plus one-cycle history for edge detection
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= data_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sync_o = sync2_q;
  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/mmio_port_responder.sv
// Data-bus MMIO responder: output port, synchronized edge-detecting input port, timer with compare.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemRead,
  input  logic                MemWrite,
  output logic [31:0]         ReadData,
  output logic                Hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  logic [4:0]          reg_ofs;
  logic                wr_en;
  logic                unused_addr_bits;

  logic [31:0]         port_out_q, port_out_d;
  logic [IN_WIDTH-1:0] edge_stat_q, edge_stat_d;
  logic [IN_WIDTH-1:0] edge_mask_q, edge_mask_d;
  logic [31:0]         tmr_count_q, tmr_count_d;
  logic [31:0]         tmr_cmp_q, tmr_cmp_d;
  logic                tmr_en_q, tmr_en_d;
  logic                tmr_flag_q, tmr_flag_d;
  logic                tmr_irq_en_q, tmr_irq_en_d;

  logic [IN_WIDTH-1:0] port_in_sync;
  logic [IN_WIDTH-1:0] port_in_rise;
  logic [IN_WIDTH-1:0] stat_clr;
  logic                flag_clr;
  logic                flag_set;
  logic                cmp_match;
  logic [31:0]         rd_data;

  assign Hit              = (Address[31:5] == BASE_ADDR[31:5]);
  assign reg_ofs          = word_to_offset(Address[4:2]);
  assign wr_en            = MemWrite & Hit;
  assign unused_addr_bits = ^Address[1:0];

  input_sync_edge #(
    .WIDTH (IN_WIDTH)
  ) u_input_sync_edge (
    .clk_i   (clk),
    .reset_i (reset),
    .data_i  (PortIn),
    .sync_o  (port_in_sync),
    .rise_o  (port_in_rise)
  );

  // Register writes; W1C requests are gathered and applied with set-wins priority below
  always_comb begin
    port_out_d   = port_out_q;
    edge_mask_d  = edge_mask_q;
    tmr_cmp_d    = tmr_cmp_q;
    tmr_en_d     = tmr_en_q;
    tmr_irq_en_d = tmr_irq_en_q;
    stat_clr     = '0;
    flag_clr     = 1'b0;
    if (wr_en) begin
      case (reg_ofs)
        OFS_PORT_OUT:  port_out_d  = WriteData;
        OFS_EDGE_STAT: stat_clr    = WriteData[IN_WIDTH-1:0];
        OFS_EDGE_MASK: edge_mask_d = WriteData[IN_WIDTH-1:0];
        OFS_TMR_CMP:   tmr_cmp_d   = WriteData;
        OFS_CTRL: begin
          tmr_en_d     = WriteData[CTRL_TMR_EN];
          flag_clr     = WriteData[CTRL_TMR_FLAG];
          tmr_irq_en_d = WriteData[CTRL_TMR_IRQ_EN];
        end
        default: ;
      endcase
    end
    edge_stat_d = (edge_stat_q & ~stat_clr) | port_in_rise;
    tmr_flag_d  = (tmr_flag_q & ~flag_clr) | flag_set;
  end

  // Compare value 0 disables matching, so the counter then free-runs and wraps
  assign cmp_match = (tmr_cmp_q != '0) && (tmr_count_q == tmr_cmp_q);

  // Timer next state: restart at 0 on a match, otherwise count up while enabled
  always_comb begin
    tmr_count_d = tmr_count_q;
    flag_set    = 1'b0;
    if (tmr_en_q) begin
      if (cmp_match) begin
        tmr_count_d = '0;
        flag_set    = 1'b1;
      end else begin
        tmr_count_d = tmr_count_q + 32'd1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      port_out_q   <= '0;
      edge_stat_q  <= '0;
      edge_mask_q  <= '0;
      tmr_count_q  <= '0;
      tmr_cmp_q    <= '0;
      tmr_en_q     <= 1'b0;
      tmr_flag_q   <= 1'b0;
      tmr_irq_en_q <= 1'b0;
    end else begin
      port_out_q   <= port_out_d;
      edge_stat_q  <= edge_stat_d;
      edge_mask_q  <= edge_mask_d;
      tmr_count_q  <= tmr_count_d;
      tmr_cmp_q    <= tmr_cmp_d;
      tmr_en_q     <= tmr_en_d;
      tmr_flag_q   <= tmr_flag_d;
      tmr_irq_en_q <= tmr_irq_en_d;
    end
  end

  // Read mux; shows pre-write state when a load and store coincide
  always_comb begin
    rd_data = '0;
    case (reg_ofs)
      OFS_PORT_OUT:  rd_data = port_out_q;
      OFS_PORT_IN:   rd_data = 32'(port_in_sync);
      OFS_EDGE_STAT: rd_data = 32'(edge_stat_q);
      OFS_EDGE_MASK: rd_data = 32'(edge_mask_q);
      OFS_TMR_COUNT: rd_data = tmr_count_q;
      OFS_TMR_CMP:   rd_data = tmr_cmp_q;
      OFS_CTRL: begin
        rd_data[CTRL_TMR_EN]     = tmr_en_q;
        rd_data[CTRL_TMR_FLAG]   = tmr_flag_q;
        rd_data[CTRL_TMR_IRQ_EN] = tmr_irq_en_q;
      end
      default: rd_data = '0;
    endcase
  end

  assign ReadData = (Hit && MemRead) ? rd_data : '0;
  assign PortOut  = port_out_q;
  assign Irq      = (|(edge_stat_q & edge_mask_q)) | (tmr_flag_q & tmr_irq_en_q);

endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder: vector table, directed corner sequences,
// then randomized traffic against a behavioural model of the register map.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        Irq;

  int n_cmp  = 0;
  int n_fail = 0;

  mmio_port_responder #(
    .BASE_ADDR (BASE),
    .IN_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .Irq       (Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_port_out, m_count, m_cmp;
  logic [7:0]  m_stat, m_mask;
  logic        m_en, m_flag, m_irqen;
  // Delay line of PortIn samples: s0 newest edge, s1 one edge older, s2 two edges older
  logic [7:0]  s0, s1, s2;

  function automatic logic m_hit(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[4:2])
      3'd0:    return m_port_out;
      3'd1:    return {24'h0, s1};
      3'd2:    return {24'h0, m_stat};
      3'd3:    return {24'h0, m_mask};
      3'd4:    return m_count;
      3'd5:    return m_cmp;
      3'd6:    return {29'h0, m_irqen, m_flag, m_en};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_irq();
    return (|(m_stat & m_mask)) | (m_flag & m_irqen);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    logic [7:0] rise, w1c;
    logic       match, fclr;
    logic [31:0] n_count;
    if (reset) begin
      m_port_out = 0; m_count = 0; m_cmp = 0; m_stat = 0; m_mask = 0;
      m_en = 0; m_flag = 0; m_irqen = 0; s0 = 0; s1 = 0; s2 = 0;
    end else begin
      rise    = s1 & ~s2;
      match   = m_en && (m_cmp != 0) && (m_count == m_cmp);
      n_count = !m_en ? m_count : (match ? 32'h0 : m_count + 32'd1);
      w1c     = 8'h0;
      fclr    = 1'b0;
      if (MemWrite && m_hit(Address)) begin
        case (Address[4:2])
          3'd0: m_port_out = WriteData;
          3'd2: w1c = WriteData[7:0];
          3'd3: m_mask = WriteData[7:0];
          3'd5: m_cmp = WriteData;
          3'd6: begin m_en = WriteData[0]; fclr = WriteData[1]; m_irqen = WriteData[2]; end
          default: ;
        endcase
      end
      m_count = n_count;
      m_stat  = (m_stat & ~w1c) | rise;
      m_flag  = (m_flag & ~fclr) | match;
      s2 = s1; s1 = s0; s0 = PortIn;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr);
    Address = a; WriteData = wd; MemRead = rd; MemWrite = wr;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wr_reg(input logic [4:0] ofs, input logic [31:0] d);
    drive(BASE + 32'(ofs), d, 1'b0, 1'b1);
    tick();
    idle();
  endtask

  task automatic rd_chk(input string name, input logic [4:0] ofs, input logic [31:0] exp);
    drive(BASE + 32'(ofs), 32'h0, 1'b1, 1'b0);
    #1;
    check(name, ReadData, exp);
    idle();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [31:0] a, wd;
    logic        rd, wr;

    m_port_out = 0; m_count = 0; m_cmp = 0; m_stat = 0; m_mask = 0;
    m_en = 0; m_flag = 0; m_irqen = 0; s0 = 0; s1 = 0; s2 = 0;
    PortIn = 8'h00;
    reset  = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    check("reset_portout", PortOut, 32'h0);
    check("reset_irq", {31'h0, Irq}, 32'h0);

    vecs[0]  = '{BASE + 32'h00, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[1]  = '{BASE + 32'h04, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[2]  = '{BASE + 32'h08, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[3]  = '{BASE + 32'h0C, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[4]  = '{BASE + 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[5]  = '{BASE + 32'h14, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[6]  = '{BASE + 32'h18, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[7]  = '{BASE + 32'h1C, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[8]  = '{32'h1001_0000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{BASE + 32'h00, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 1'b1};
    vecs[10] = '{BASE + 32'h00, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[11] = '{BASE + 32'h04, 32'h55, 1'b0, 1'b1, 32'h0, 1'b1};
    vecs[12] = '{BASE + 32'h04, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[13] = '{BASE + 32'h1C, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b1};
    vecs[14] = '{BASE + 32'h1C, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[15] = '{BASE + 32'h03, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[16] = '{32'h1001_0000, 32'h1234, 1'b0, 1'b1, 32'h0, 1'b0};
    vecs[17] = '{BASE + 32'h00, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[18] = '{BASE + 32'h14, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1};

    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr);
      #1;
      check($sformatf("vec%0d_rdata", i), ReadData, vecs[i].exp_rdata);
      check($sformatf("vec%0d_hit", i), {31'h0, Hit}, {31'h0, vecs[i].exp_hit});
      tick();
    end
    idle();
    check("portout_after_store", PortOut, 32'hDEAD_BEEF);

    // Input edge path
    wr_reg(5'h0C, 32'h1);
    PortIn = 8'h01;
    tick();
    rd_chk("port_in_after_e0", 5'h04, 32'h0);
    tick();
    rd_chk("port_in_after_e1", 5'h04, 32'h1);
    check("irq_after_e1", {31'h0, Irq}, 32'h0);
    tick();
    rd_chk("edge_stat_after_e2", 5'h08, 32'h1);
    check("irq_after_e2", {31'h0, Irq}, 32'h1);
    wr_reg(5'h08, 32'h1);
    check("irq_after_w1c", {31'h0, Irq}, 32'h0);
    rd_chk("edge_stat_after_w1c", 5'h08, 32'h0);
    PortIn = 8'h00;
    repeat (3) tick();
    PortIn = 8'h01;
    tick();
    tick();
    wr_reg(5'h08, 32'h1);
    rd_chk("edge_stat_set_wins", 5'h08, 32'h1);
    check("irq_set_wins", {31'h0, Irq}, 32'h1);
    wr_reg(5'h08, 32'h1);
    wr_reg(5'h0C, 32'h0);

    // Timer compare sequence
    wr_reg(5'h14, 32'd3);
    wr_reg(5'h18, 32'h5);
    rd_chk("tmr_count_w", 5'h10, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      rd_chk($sformatf("tmr_count_w%0d", k), 5'h10, 32'(k));
      check($sformatf("tmr_irq_w%0d", k), {31'h0, Irq}, 32'h0);
    end
    tick();
    rd_chk("tmr_count_wrap", 5'h10, 32'd0);
    rd_chk("tmr_ctrl_flag", 5'h18, 32'h7);
    check("tmr_irq_flag", {31'h0, Irq}, 32'h1);
    wr_reg(5'h18, 32'h2);
    rd_chk("tmr_ctrl_cleared", 5'h18, 32'h0);
    check("tmr_irq_cleared", {31'h0, Irq}, 32'h0);
    rd_chk("tmr_count_halt0", 5'h10, 32'd1);
    tick();
    rd_chk("tmr_count_halt1", 5'h10, 32'd1);

    // Load and store in the same cycle
    wr_reg(5'h0C, 32'h0F);
    drive(BASE + 32'h0C, 32'hF0, 1'b1, 1'b1);
    #1;
    check("rw_same_cycle_old", ReadData, 32'h0F);
    tick();
    idle();
    rd_chk("rw_same_cycle_new", 5'h0C, 32'hF0);

    // Reset mid-operation
    PortIn = 8'h81;
    wr_reg(5'h0C, 32'h80);
    wr_reg(5'h18, 32'h1);
    tick();
    tick();
    rd_chk("pre_reset_stat", 5'h08, 32'h80);
    check("pre_reset_irq", {31'h0, Irq}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset_portout", PortOut, 32'h0);
    check("post_reset_irq", {31'h0, Irq}, 32'h0);
    for (int o = 0; o < 8; o++) begin
      rd_chk($sformatf("post_reset_ofs%0d", o * 4), 5'(o * 4), 32'h0);
    end
    tick();
    rd_chk("rst_edge1_stat", 5'h08, 32'h0);
    tick();
    rd_chk("rst_edge2_stat", 5'h08, 32'h0);
    tick();
    rd_chk("rst_edge3_stat", 5'h08, 32'h81);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) != 0) a = BASE | 32'($urandom_range(0, 31));
      else a = $urandom;
      wd = $urandom;
      if (a[4:2] == 3'd5) wd = 32'($urandom_range(0, 12));
      if (a[4:2] == 3'd6) wd = 32'($urandom_range(0, 7));
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) PortIn = 8'($urandom);
      drive(a, wd, rd, wr);
      #1;
      check("rand_rdata", ReadData, (m_hit(a) && rd) ? m_read(a) : 32'h0);
      check("rand_hit", {31'h0, Hit}, {31'h0, m_hit(a)});
      tick();
      check("rand_portout", PortOut, m_port_out);
      check("rand_irq", {31'h0, Irq}, {31'h0, m_irq()});
    end
    reset = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
